// File: rtl/ga_int_sync.sv
// Gate-array interrupt/sync stage: 52-line raster interrupt counter with VSYNC
// resynchronisation, Z80 acknowledge, and shaped monitor HSYNC/VSYNC pulses.
module ga_int_sync #(
  parameter int HS_DELAY = 2,
  parameter int HS_WIDTH = 4,
  parameter int VS_DELAY = 2,
  parameter int VS_WIDTH = 4
) (
  input  logic       CLOCK,
  input  logic       nRESET,
  input  logic       CLKEN,
  input  logic       HSYNC_IN,
  input  logic       VSYNC_IN,
  input  logic       INT_ACK,
  input  logic       RMR_WR,
  input  logic       RMR_D4,
  output logic       INT,
  output logic       MON_HSYNC,
  output logic       MON_VSYNC,
  output logic [5:0] INT_CNT
);

  logic       hs_s, hs_p, vs_s, vs_p;
  logic       hs_fall, hs_rise, vs_rise;
  logic       rs_pend, rs_first, rs_pend_n, rs_first_n;
  logic       resync, set;
  logic [5:0] cnt_r, cnt_n;
  logic       int_r, int_n;
  logic [1:0] sh_clr, sh_inc, sh_lvl, sh_out;

  always_ff @(posedge CLOCK) begin
    if (!nRESET) begin
      hs_s <= 1'b0;
      hs_p <= 1'b0;
      vs_s <= 1'b0;
      vs_p <= 1'b0;
    end else if (CLKEN) begin
      hs_p <= hs_s;
      hs_s <= HSYNC_IN;
      vs_p <= vs_s;
      vs_s <= VSYNC_IN;
    end
  end

  assign hs_fall = hs_p & ~hs_s;
  assign hs_rise = hs_s & ~hs_p;
  assign vs_rise = vs_s & ~vs_p;

  // A vs_rise restarts the two-line resync window, even if an hs_fall lands
  // on the same character; that hs_fall then counts normally.
  always_comb begin
    cnt_n      = cnt_r;
    int_n      = int_r;
    rs_pend_n  = rs_pend;
    rs_first_n = rs_first;
    resync     = 1'b0;
    set        = 1'b0;
    if (CLKEN) begin
      if (vs_rise) begin
        rs_pend_n  = 1'b1;
        rs_first_n = 1'b0;
      end else if (hs_fall && rs_pend) begin
        if (rs_first) begin
          resync     = 1'b1;
          rs_pend_n  = 1'b0;
          rs_first_n = 1'b0;
        end else begin
          rs_first_n = 1'b1;
        end
      end
      if (hs_fall) begin
        if (resync) begin
          set   = cnt_r[5];
          cnt_n = '0;
        end else if (cnt_r == 6'd51) begin
          set   = 1'b1;
          cnt_n = '0;
        end else begin
          cnt_n = cnt_r + 6'd1;
        end
      end
    end
    // A coincident set swallows the acknowledge entirely.
    if (set) begin
      int_n = 1'b1;
    end else if (INT_ACK) begin
      int_n    = 1'b0;
      cnt_n[5] = 1'b0;
    end
    if (RMR_WR && RMR_D4) begin
      int_n = 1'b0;
      cnt_n = '0;
    end
  end

  always_ff @(posedge CLOCK) begin
    if (!nRESET) begin
      cnt_r    <= '0;
      int_r    <= 1'b0;
      rs_pend  <= 1'b0;
      rs_first <= 1'b0;
    end else begin
      cnt_r    <= cnt_n;
      int_r    <= int_n;
      rs_pend  <= rs_pend_n;
      rs_first <= rs_first_n;
    end
  end

  // Channel 0 counts characters of HSYNC, channel 1 counts lines of VSYNC.
  assign sh_clr = {vs_rise, hs_rise};
  assign sh_inc = {hs_fall & vs_s, hs_s};
  assign sh_lvl = {vs_s, hs_s};

  for (genvar g = 0; g < 2; g++) begin : g_shape
    localparam int DLY = (g == 0) ? HS_DELAY : VS_DELAY;
    localparam int WID = (g == 0) ? HS_WIDTH : VS_WIDTH;
    logic [3:0] cnt, nxt;
    logic       pulse;

    always_comb begin
      nxt = cnt;
      if (sh_clr[g])
        nxt = '0;
      else if (sh_inc[g] && cnt != 4'hf)
        nxt = cnt + 4'd1;
    end

    always_ff @(posedge CLOCK) begin
      if (!nRESET) begin
        cnt   <= '0;
        pulse <= 1'b0;
      end else if (CLKEN) begin
        cnt   <= nxt;
        pulse <= sh_lvl[g] && (int'(nxt) >= DLY) && (int'(nxt) <= DLY + WID - 1);
      end
    end

    assign sh_out[g] = pulse;
  end

  assign INT       = int_r;
  assign INT_CNT   = cnt_r;
  assign MON_HSYNC = sh_out[0];
  assign MON_VSYNC = sh_out[1];

endmodule

// File: tb/tb_ga_int_sync.sv
// Bench for ga_int_sync: vector table, directed raster sequences and a random
// raster compared every CLOCK against a sample-history reference model.
module tb_ga_int_sync;
  logic       CLOCK = 1'b0, nRESET = 1'b0, CLKEN = 1'b0;
  logic       HSYNC_IN = 1'b0, VSYNC_IN = 1'b0;
  logic       INT_ACK = 1'b0, RMR_WR = 1'b0, RMR_D4 = 1'b0;
  logic       INT, MON_HSYNC, MON_VSYNC;
  logic [5:0] INT_CNT;

  int total = 0, bad = 0, mh_cnt = 0, mv_cnt = 0;
  int r_len, r_hw, vrem, gap;
  bit r_v, r_d4;

  always #5 CLOCK = ~CLOCK;

  ga_int_sync dut (
    .CLOCK(CLOCK), .nRESET(nRESET), .CLKEN(CLKEN),
    .HSYNC_IN(HSYNC_IN), .VSYNC_IN(VSYNC_IN),
    .INT_ACK(INT_ACK), .RMR_WR(RMR_WR), .RMR_D4(RMR_D4),
    .INT(INT), .MON_HSYNC(MON_HSYNC), .MON_VSYNC(MON_VSYNC), .INT_CNT(INT_CNT)
  );

  // Reference model: full history of sampled sync levels plus spec-level counters.
  bit hq[$], vq[$];
  bit m_int, m_mh, m_mv, m_pend;
  int m_cnt, m_falls, m_vl;

  function automatic bit in_win(input int c, input int d, input int w);
    return (c >= d) && (c <= d + w - 1);
  endfunction

  task automatic model_reset();
    hq.delete(); vq.delete();
    hq.push_back(1'b0); hq.push_back(1'b0);
    vq.push_back(1'b0); vq.push_back(1'b0);
    m_int = 0; m_mh = 0; m_mv = 0; m_pend = 0;
    m_cnt = 0; m_falls = 0; m_vl = 0;
  endtask

  task automatic model_step(input bit ce, input bit ack, input bit rmr, input bit d4,
                            input bit h, input bit v, input bit rst_n);
    int  n, run;
    bit  fall, rise, do_a, set;
    if (!rst_n) begin
      model_reset();
      return;
    end
    set = 0;
    if (ce) begin
      n    = hq.size();
      fall = hq[n-2] && !hq[n-1];
      rise = !vq[n-2] && vq[n-1];
      run  = 0;
      for (int i = n - 1; i >= 0 && hq[i] && run < 17; i--) run++;
      m_mh = (run > 0) && in_win((run - 1 > 15) ? 15 : run - 1, 2, 4);
      do_a = 0;
      if (rise) begin
        m_pend = 1; m_falls = 0;
      end else if (fall && m_pend) begin
        m_falls++;
        if (m_falls == 2) begin do_a = 1; m_pend = 0; end
      end
      if (fall) begin
        if (do_a) begin set = (m_cnt >= 32); m_cnt = 0; end
        else if (m_cnt == 51) begin set = 1; m_cnt = 0; end
        else m_cnt++;
      end
      if (rise) m_vl = 0;
      else if (fall && vq[n-1] && m_vl < 15) m_vl++;
      m_mv = vq[n-1] && in_win(m_vl, 2, 4);
      hq.push_back(h);
      vq.push_back(v);
    end
    if (set) m_int = 1;
    else if (ack) begin m_int = 0; m_cnt = m_cnt % 32; end
    if (rmr && d4) begin m_int = 0; m_cnt = 0; end
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick(input bit ce, input bit ack, input bit rmr, input bit d4);
    logic [8:0] e, a;
    CLKEN = ce; INT_ACK = ack; RMR_WR = rmr; RMR_D4 = d4;
    model_step(ce, ack, rmr, d4, HSYNC_IN, VSYNC_IN, nRESET);
    @(posedge CLOCK); #1;
    e = {m_int, m_cnt[5:0], m_mh, m_mv};
    a = {INT, INT_CNT, MON_HSYNC, MON_VSYNC};
    chk("model", int'(a), int'(e));
    if (ce && MON_HSYNC) mh_cnt++;
    if (ce && MON_VSYNC) mv_cnt++;
    CLKEN = 0; INT_ACK = 0; RMR_WR = 0; RMR_D4 = 0;
  endtask

  task automatic chr(input bit h, input bit v, input bit ack, input bit rmr, input bit d4);
    HSYNC_IN = h; VSYNC_IN = v;
    tick(0, 0, 0, 0);
    tick(1, ack, rmr, d4);
  endtask

  task automatic line(input int len, input int hw, input bit v,
                      input int ack_at, input int rmr_at, input bit d4);
    for (int c = 0; c < len; c++) chr(c < hw, v, c == ack_at, c == rmr_at, d4);
  endtask

  task automatic lines(input int n, input bit v);
    for (int i = 0; i < n; i++) line(20, 6, v, -1, -1, 0);
  endtask

  task automatic do_reset();
    nRESET = 0;
    tick(0, 0, 0, 0);
    chk("rst_int", int'(INT), 0);
    chk("rst_cnt", int'(INT_CNT), 0);
    chk("rst_mh", int'(MON_HSYNC), 0);
    chk("rst_mv", int'(MON_VSYNC), 0);
    nRESET = 1;
  endtask

  typedef struct {
    bit h, v, ack, rmr, d4;
    bit e_int; int e_cnt; bit e_mh, e_mv;
  } vec_t;
  vec_t tbl[8];

  initial begin
    tbl[0] = '{1, 0, 0, 0, 0, 0, 0, 0, 0};
    tbl[1] = '{1, 0, 0, 0, 0, 0, 0, 0, 0};
    tbl[2] = '{1, 0, 0, 0, 0, 0, 0, 0, 0};
    tbl[3] = '{0, 0, 0, 0, 0, 0, 0, 1, 0};  // 3-char HSYNC: pulse only at char 2
    tbl[4] = '{0, 0, 0, 0, 0, 0, 1, 0, 0};
    tbl[5] = '{0, 0, 1, 0, 0, 0, 1, 0, 0};
    tbl[6] = '{0, 0, 0, 1, 0, 0, 1, 0, 0};
    tbl[7] = '{0, 0, 0, 1, 1, 0, 0, 0, 0};

    model_reset();
    do_reset();
    for (int i = 0; i < 8; i++) begin
      chr(tbl[i].h, tbl[i].v, tbl[i].ack, tbl[i].rmr, tbl[i].d4);
      chk($sformatf("tbl%0d_int", i), int'(INT), int'(tbl[i].e_int));
      chk($sformatf("tbl%0d_cnt", i), int'(INT_CNT), tbl[i].e_cnt);
      chk($sformatf("tbl%0d_mh", i), int'(MON_HSYNC), int'(tbl[i].e_mh));
      chk($sformatf("tbl%0d_mv", i), int'(MON_VSYNC), int'(tbl[i].e_mv));
    end

    // Steady raster: 64-char lines, 14-char HSYNC
    do_reset();
    for (int l = 1; l <= 53; l++) begin
      mh_cnt = 0;
      line(64, 14, 0, -1, -1, 0);
      chk("raster_cnt", int'(INT_CNT), l % 52);
      chk("raster_int", int'(INT), int'(l >= 52));
      chk("hs_width", mh_cnt, 4);
    end
    tick(0, 1, 0, 0);
    chk("ack_int", int'(INT), 0);
    chk("ack_cnt", int'(INT_CNT), 1);
    line(64, 14, 0, -1, -1, 0);
    chk("ack_next_cnt", int'(INT_CNT), 2);
    chk("ack_next_int", int'(INT), 0);

    // Ack on the hs_fall that sets INT is lost
    do_reset(); lines(51, 0);
    line(20, 6, 0, 7, -1, 0);
    chk("ack_vs_set_int", int'(INT), 1);
    chk("ack_vs_set_cnt", int'(INT_CNT), 0);

    // Ack on a plain increment: 40 -> 41 with bit5 cleared
    do_reset(); lines(40, 0);
    line(20, 6, 0, 7, -1, 0);
    chk("ack_inc_cnt", int'(INT_CNT), 9);
    chk("ack_inc_int", int'(INT), 0);

    // RMR clear on the 52nd line
    do_reset(); lines(51, 0);
    line(20, 6, 0, -1, 7, 1);
    chk("rmr1_int", int'(INT), 0);
    chk("rmr1_cnt", int'(INT_CNT), 0);
    do_reset(); lines(51, 0);
    line(20, 6, 0, -1, 7, 0);
    chk("rmr0_int", int'(INT), 1);
    chk("rmr0_cnt", int'(INT_CNT), 0);

    // VSYNC at count 40, then reset mid-VSYNC with INT set
    do_reset(); lines(40, 0);
    lines(1, 1);
    chk("vs40_l1_cnt", int'(INT_CNT), 41);
    lines(1, 1);
    chk("vs40_int", int'(INT), 1);
    chk("vs40_cnt", int'(INT_CNT), 0);
    lines(2, 1);
    chk("vs40_mv", int'(MON_VSYNC), 1);
    do_reset();
    lines(1, 1);
    chk("post_rst_cnt", int'(INT_CNT), 1);
    lines(1, 1);
    chk("post_rst_resync_cnt", int'(INT_CNT), 0);
    chk("post_rst_resync_int", int'(INT), 0);
    lines(2, 0);

    // VSYNC at count 20, 16 lines long
    do_reset(); lines(20, 0);
    mv_cnt = 0;
    lines(1, 1);
    chk("vs20_l1_cnt", int'(INT_CNT), 21);
    lines(1, 1);
    chk("vs20_int", int'(INT), 0);
    chk("vs20_cnt", int'(INT_CNT), 0);
    lines(14, 1);
    lines(2, 0);
    chk("vs_width", mv_cnt, 80);

    // Random raster with random acks and RMR writes
    vrem = 0;
    for (int l = 0; l < 150; l++) begin
      if (l == 75) do_reset();
      r_len = $urandom_range(12, 60);
      r_hw  = $urandom_range(1, 16);
      if (vrem > 0) vrem--;
      else if ($urandom_range(0, 9) == 0) vrem = $urandom_range(1, 18);
      r_v = (vrem > 0);
      for (int c = 0; c < r_len; c++) begin
        HSYNC_IN = (c < r_hw); VSYNC_IN = r_v;
        gap = $urandom_range(0, 3);
        for (int g = 0; g <= gap; g++) begin
          r_d4 = 1'($urandom_range(0, 1));
          tick(g == gap, $urandom_range(0, 150) == 0, $urandom_range(0, 600) == 0, r_d4);
        end
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
